load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEMORY_SIZE, default 4096, number of 32-bit words in the downstream Memory.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_i, input, 1, access request from datapath; sampled only in IDLE.
REQ-005 SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port size_i, input, 2, 00 byte, 01 halfword, 10 word, 11 invalid.
REQ-007 SHALL have port unsigned_i, input, 1, 1 = zero-extend loads, 0 = sign-extend.
REQ-008 SHALL have port addr_i, input, 32, byte address.
REQ-009 SHALL have port wdata_i, input, 32, store data; valid bits in LSBs for sub-word sizes.
REQ-010 SHALL have port rdata_o, output, 32, extended load result; held until next accepted request.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1, valid with done_o; 1 = access rejected.
REQ-013 SHALL have port busy_o, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have ports mem_rd_en_o, mem_wr_en_o (1 bit each), mem_addr_o, mem_wdata_o (32 bits each), outputs to the Memory.
REQ-015 SHALL have port mem_rdata_i, input, 32, combinational read data from Memory for the current mem_addr_o.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
REQ-017 In IDLE with req_i=1, SHALL latch we_i, size_i, unsigned_i, addr_i, wdata_i and transition the same edge; req_i in any other state SHALL be ignored.
REQ-018 Error check at acceptance: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEMORY_SIZE -> go DONE, err_o=1, rdata_o=0, no memory enable asserted.
REQ-019 Legal load -> LOAD: mem_rd_en_o=1, mem_addr_o={addr[31:2],2'b00}; at LOAD end, extracted lane captured into rdata_o; -> DONE.
REQ-020 Lane selection little-endian: byte lane = addr[1:0], halfword lane = addr[1]; sub-word results extended per unsigned_i to 32 bits.
REQ-021 Legal word store -> STORE: mem_wr_en_o=1, mem_wdata_o=latched wdata; -> DONE.
REQ-022 Legal byte/halfword store -> RMW_RD: mem_rd_en_o=1, mem_rdata_i captured into merge register; -> RMW_WR: mem_wr_en_o=1, mem_wdata_o = merged word (only target lane replaced by wdata LSBs); -> DONE.
REQ-023 DONE: done_o=1 for exactly one cycle, then IDLE; a new req_i is accepted no earlier than the cycle after DONE.
REQ-024 Latency from accepting edge to done_o high: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-025 mem_rd_en_o and mem_wr_en_o SHALL never be high simultaneously; both 0 in IDLE and DONE; mem_addr_o always word-aligned.
REQ-026 Stores SHALL leave rdata_o unchanged from its previous value; err_o=0 on every legal completion.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, clear latched request and merge register, rdata_o=0, done_o=0, err_o=0, busy_o=0, all mem_* outputs 0, regardless of state.
REQ-028 Reset during RMW_RD SHALL prevent the subsequent write; no mem_wr_en_o pulse after the reset edge.
REQ-029 rst has priority over req_i on the same edge.

Verification
REQ-030 Memory word 0x10 = 0x8899AABB; load byte addr 0x12 signed -> rdata_o=0xFFFFFF99, done_o 2 cycles after accept, err_o=0.
REQ-031 Same word, load halfword addr 0x12 unsigned -> rdata_o=0x00008899; load word addr 0x10 -> 0x8899AABB.
REQ-032 Store byte wdata 0x123456CC to addr 0x11 -> one mem_rd_en_o cycle, then one mem_wr_en_o cycle with mem_wdata_o=0x8899CCBB, done_o 3 cycles after accept; later word load returns 0x8899CCBB.
REQ-033 Word load addr 0x13, halfword store addr 0x15, size 11, addr 0x4000 (MEMORY_SIZE=4096) -> each done_o+err_o after 1 cycle, no memory enables, memory unchanged.
REQ-034 req_i held high throughout -> back-to-back accepts spaced by full latency+1; busy_o low only in IDLE cycles.
REQ-035 rst asserted during RMW_RD of a byte store -> next cycle IDLE, all outputs 0, target word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a word-wide memory.
// Sub-word stores are done as a read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    DONE
  } state_e;

  localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic        accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && req_i;

  always_comb begin
    req_err = 1'b0;
    if (size_i == 2'b11)                            req_err = 1'b1;
    if (size_i == 2'b01 && addr_i[0])               req_err = 1'b1;
    if (size_i == 2'b10 && addr_i[1:0] != 2'b00)    req_err = 1'b1;
    if ({2'b00, addr_i[31:2]} >= MEM_WORDS)         req_err = 1'b1;
  end

  // State register and request/data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        err_q   <= req_err;
        if (req_err) rdata_q <= '0;
      end
      if (state_q == LOAD)   rdata_q <= load_ext;
      if (state_q == RMW_RD) merge_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (req_err)              state_d = DONE;
          else if (!we_i)           state_d = LOAD;
          else if (size_i == 2'b10) state_d = STORE;
          else                      state_d = RMW_RD;
        end
      end
      LOAD:    state_d = DONE;
      STORE:   state_d = DONE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane extraction with sign/zero extension
  always_comb begin
    load_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    load_half = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_ext = uns_q ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    merged = merge_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = merge_q;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    err_o       = (state_q == DONE) && err_q;
    rdata_o     = rdata_q;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      LOAD, RMW_RD: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
      end
      STORE: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = wdata_q;
      end
      RMW_WR: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = merged;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        done, err, busy, mem_rd, mem_wr;

  logic [31:0] mem [0:4095];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEMORY_SIZE(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .unsigned_i  (uns),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .mem_rd_en_o (mem_rd),
    .mem_wr_en_o (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[13:2]] <= mem_wdata;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_rd;
    int unsigned exp_wr;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee,
                              input int unsigned lat, input int unsigned nrd,
                              input int unsigned nwr, input logic [31:0] mwd);
    vec_t v;
    v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    v.exp_rd = nrd; v.exp_wr = nwr; v.exp_mwdata = mwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned lat, nrd, nwr;
    logic        bus_ok;
    logic [31:0] mw;
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0; nrd = 0; nwr = 0; bus_ok = 1'b1; mw = '0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_rd && mem_wr) bus_ok = 1'b0;
      if (mem_addr[1:0] != 2'b00) bus_ok = 1'b0;
      if (done) begin
        lat = c;
        if (mem_rd || mem_wr) bus_ok = 1'b0;
        break;
      end
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; mw = mem_wdata; end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    chk($sformatf("v%0d rd_cycles", idx), nrd, v.exp_rd);
    chk($sformatf("v%0d wr_cycles", idx), nwr, v.exp_wr);
    chk($sformatf("v%0d bus_ok", idx), {31'b0, bus_ok}, 32'd1);
    if (v.exp_wr != 0) chk($sformatf("v%0d mem_wdata", idx), mw, v.exp_mwdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_after", idx), {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " rdata"}, rdata, 32'h0);
    chk({name, " flags"}, {26'b0, done, err, busy, mem_rd, mem_wr, 1'b0}, 32'h0);
    chk({name, " mem_addr"}, mem_addr, 32'h0);
    chk({name, " mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    logic [8:0] busy_pat, done_pat;
    int unsigned wr_seen;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;

    //        we    size  uns   addr          wdata         rdata         err   lat rd wr mwdata
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h00000012, 32'h0,        32'hFFFFFF99, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h00000012, 32'h0,        32'h00008899, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h00000010, 32'h0,        32'h000000BB, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h00000010, 32'h0,        32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h00000011, 32'h123456CC, 32'hFFFFAABB, 1'b0, 3, 1, 1, 32'h8899CCBB));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        32'h8899CCBB, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00000013, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h00000015, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00000014, 32'h0,        32'h11223344, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h00000014, 32'hDEADBEEF, 32'h11223344, 1'b0, 2, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h00000016, 32'h0000CAFE, 32'h11223344, 1'b0, 3, 1, 1, 32'hCAFEBEEF));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h00000017, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h00000016, 32'h0,        32'h0000CAFE, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h00000013, 32'hFF000077, 32'h0000CAFE, 1'b0, 3, 1, 1, 32'h7799CCBB));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0,        32'h00000077, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        32'h7799CCBB, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00003FFC, 32'h0,        32'h00000000, 1'b0, 2, 1, 0, 32'h0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    foreach (vecs[i]) run_vec(i, vecs[i]);
    chk("mem4 final", mem[4], 32'h7799CCBB);
    chk("mem5 final", mem[5], 32'hCAFEBEEF);

    // Reset during RMW_RD must suppress the pending write
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h10; wdata = 32'h000000AA;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rmw_rd entered", {30'b0, mem_rd, mem_wr}, 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_in_rmw");
    rst = 1'b0;
    wr_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_wr) wr_seen++;
    end
    chk("rst_in_rmw no write", wr_seen, 32'd0);
    chk("rst_in_rmw mem4", mem[4], 32'h7799CCBB);

    // Reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    chk("rst_prio busy", {31'b0, busy}, 32'd0);
    chk("rst_prio rd_en", {31'b0, mem_rd}, 32'd0);

    // Request held high: accepts every latency+1 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      busy_pat[8 - c] = busy;
      done_pat[8 - c] = done;
    end
    req = 1'b0;
    chk("b2b busy pattern", {23'b0, busy_pat}, {23'b0, 9'b110110110});
    chk("b2b done pattern", {23'b0, done_pat}, {23'b0, 9'b010010010});
    chk("b2b rdata", rdata, 32'h7799CCBB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
